// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states, instruction field positions, flag indices.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'h0, OP_OR   = 4'h1, OP_ADD  = 4'h2, OP_ADDI = 4'h3,
    OP_ANDI = 4'h4, OP_SUB  = 4'h5, OP_XOR  = 4'h6, OP_CMP  = 4'h7,
    OP_LD   = 4'h8, OP_ST   = 4'h9, OP_JMP  = 4'hA, OP_BEQ  = 4'hB,
    OP_BNE  = 4'hC, OP_BC   = 4'hD, OP_NOP  = 4'hE, OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int unsigned INSTR_W = 18;
  localparam int unsigned OP_HI   = 17;
  localparam int unsigned OP_LO   = 14;
  localparam int unsigned RD_HI   = 13;
  localparam int unsigned RD_LO   = 10;
  localparam int unsigned RS1_HI  = 9;
  localparam int unsigned RS1_LO  = 6;
  localparam int unsigned RS2_HI  = 3;
  localparam int unsigned RS2_LO  = 0;
  localparam int unsigned IMM_HI  = 5;

  localparam int unsigned FLAG_Z  = 0;
  localparam int unsigned FLAG_C  = 1;

endpackage

// File: rtl/cpu_regfile_p.sv
// Register file: two asynchronous read ports, one synchronous write port, asynchronous clear.
module cpu_regfile_p #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        ra_i,
  input  logic [3:0]        rb_i,
  input  logic              we_i,
  input  logic [3:0]        wa_i,
  input  logic [DATA_W-1:0] wd_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o
);

  localparam int unsigned IW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (32'(wa_i) < NREGS)) begin
      regs_q[wa_i[IW-1:0]] <= wd_i;
    end
  end

  // Indices beyond the implemented registers read as zero.
  assign ra_data_o = (32'(ra_i) < NREGS) ? regs_q[ra_i[IW-1:0]] : '0;
  assign rb_data_o = (32'(rb_i) < NREGS) ? regs_q[rb_i[IW-1:0]] : '0;

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB FSM with handshaked instruction and data memories.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned PC_RST = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               retire,
  output logic               halted,
  output logic [ADDR_W-1:0]  dbg_pc,
  output logic [2:0]         dbg_state
);

  state_e               state_q;
  logic [INSTR_W-1:0]   ir_q;
  logic [ADDR_W-1:0]    pc_q;
  logic [DATA_W-1:0]    a_q, b_q, res_q;
  logic [1:0]           flags_q;
  logic                 retire_q, halted_q;

  opcode_e              op;
  logic [3:0]           rd, rs1, rs2;
  logic [DATA_W-1:0]    imm_ext, rf_a, rf_b;
  logic [ADDR_W-1:0]    off_ext, pc_inc, pc_tgt;
  logic [DATA_W:0]      alu_wide;
  logic                 take;

  assign op      = opcode_e'(ir_q[OP_HI:OP_LO]);
  assign rd      = ir_q[RD_HI:RD_LO];
  assign rs1     = ir_q[RS1_HI:RS1_LO];
  assign rs2     = ir_q[RS2_HI:RS2_LO];
  assign imm_ext = {{(DATA_W-6){ir_q[IMM_HI]}}, ir_q[IMM_HI:0]};
  assign off_ext = ir_q[ADDR_W-1:0];
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign pc_tgt  = pc_inc + off_ext;

  cpu_regfile_p #(.DATA_W(DATA_W), .NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .ra_i      (rs1),
    .rb_i      ((op == OP_ST) ? rd : rs2),
    .we_i      ((state_q == S_WB) && (op != OP_CMP)),
    .wa_i      (rd),
    .wd_i      (res_q),
    .ra_data_o (rf_a),
    .rb_data_o (rf_b)
  );

  // Extra top bit carries ADD carry-out / SUB borrow; logic ops leave it zero.
  always_comb begin
    alu_wide = '0;
    case (op)
      OP_AND, OP_ANDI: alu_wide = {1'b0, a_q & b_q};
      OP_OR:           alu_wide = {1'b0, a_q | b_q};
      OP_XOR:          alu_wide = {1'b0, a_q ^ b_q};
      OP_ADD, OP_ADDI: alu_wide = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB, OP_CMP:  alu_wide = {1'b0, a_q} - {1'b0, b_q};
      default:         alu_wide = '0;
    endcase
  end

  always_comb begin
    take = 1'b0;
    case (op)
      OP_JMP:  take = 1'b1;
      OP_BEQ:  take = flags_q[FLAG_Z];
      OP_BNE:  take = ~flags_q[FLAG_Z];
      OP_BC:   take = flags_q[FLAG_C];
      default: take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= ADDR_W'(PC_RST);
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: if (imem_ack) begin
          ir_q    <= imem_rdata;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          a_q     <= rf_a;
          b_q     <= (op == OP_ADDI || op == OP_ANDI) ? imm_ext : rf_b;
          state_q <= S_EXEC;
        end
        S_EXEC: case (op)
          OP_AND, OP_OR, OP_ADD, OP_ADDI, OP_ANDI, OP_SUB, OP_XOR, OP_CMP: begin
            res_q           <= alu_wide[DATA_W-1:0];
            flags_q[FLAG_C] <= alu_wide[DATA_W];
            flags_q[FLAG_Z] <= ~|alu_wide[DATA_W-1:0];
            pc_q            <= pc_inc;
            state_q         <= S_WB;
          end
          OP_LD, OP_ST: state_q <= S_MEM;
          OP_HALT: begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
            retire_q <= 1'b1;
          end
          default: begin
            pc_q     <= take ? pc_tgt : pc_inc;
            state_q  <= S_FETCH;
            retire_q <= 1'b1;
          end
        endcase
        S_MEM: if (dmem_ack) begin
          if (op == OP_LD) begin
            res_q   <= dmem_rdata;
            state_q <= S_WB;
          end else begin
            pc_q     <= pc_inc;
            state_q  <= S_FETCH;
            retire_q <= 1'b1;
          end
        end
        S_WB: begin
          if (op == OP_LD) pc_q <= pc_inc;
          state_q  <= S_FETCH;
          retire_q <= 1'b1;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Reset parks the FSM in FETCH, so the fetch request is masked by reset to drop at once.
  assign imem_req   = (state_q == S_FETCH) && !reset;
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (op == OP_ST);
  assign dmem_addr  = off_ext;
  assign dmem_wdata = b_q;
  assign retire     = retire_q;
  assign halted     = halted_q;
  assign dbg_pc     = pc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Bench for cpu_multicycle: handshaked memory models plus retire/data-access scoreboards.
module tb_cpu_multicycle;
  import cpu_pkg::*;

  localparam int unsigned DW = 18;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted;
  logic [AW-1:0] imem_addr, dmem_addr, dbg_pc;
  logic [17:0]   imem_rdata;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  cpu_multicycle #(.DATA_W(DW), .ADDR_W(AW), .NREGS(16), .PC_RST(0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .retire(retire), .halted(halted), .dbg_pc(dbg_pc), .dbg_state(dbg_state)
  );

  typedef struct { int unsigned pc; int unsigned lat; } ret_t;
  typedef struct { bit we; int unsigned addr; logic [DW-1:0] data; } mem_t;

  logic [17:0]   imem [1024];
  logic [DW-1:0] dmem [1024];
  ret_t          ret_q[$];
  mem_t          mem_q[$];
  int unsigned   imem_wait = 0, dmem_wait = 0;
  bit            imem_hold = 1'b1, stray = 1'b0;
  int            n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [17:0] enc_r(opcode_e op, int unsigned rd, int unsigned rs1, int unsigned rs2);
    return {op, 4'(rd), 4'(rs1), 2'b00, 4'(rs2)};
  endfunction
  function automatic logic [17:0] enc_i(opcode_e op, int unsigned rd, int unsigned rs1, int imm);
    return {op, 4'(rd), 4'(rs1), 6'(imm)};
  endfunction
  function automatic logic [17:0] enc_o(opcode_e op, int unsigned rd, int off);
    return {op, 4'(rd), 10'(off)};
  endfunction

  task automatic exp_ret(input int unsigned pc, input int unsigned lat);
    ret_t r;
    r.pc = pc; r.lat = lat;
    ret_q.push_back(r);
  endtask
  task automatic exp_mem(input bit we, input int unsigned addr, input logic [DW-1:0] data);
    mem_t m;
    m.we = we; m.addr = addr; m.data = data;
    mem_q.push_back(m);
  endtask

  // Instruction memory: acks after imem_wait idle cycles; stray mode acks with nobody asking.
  initial begin
    int unsigned w;
    logic [17:0] junk;
    w = 0;
    junk = enc_o(OP_JMP, 0, -1);
    imem_ack = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (imem_req && !imem_hold) begin
        if (w >= imem_wait) begin
          imem_ack = 1'b1; imem_rdata = imem[imem_addr]; w = 0;
        end else begin
          imem_ack = 1'b0; w++;
        end
      end else begin
        imem_ack = stray; imem_rdata = junk; w = 0;
      end
    end
  end

  // Data memory: every request cycle is compared against the head of the expected-access queue.
  initial begin
    int unsigned w;
    mem_t m;
    w = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        if (mem_q.size() == 0) begin
          chk("dmem_unexpected", 32'(dmem_req), 0);
          dmem_ack = 1'b1;
        end else begin
          m = mem_q[0];
          chk("dmem_we", 32'(dmem_we), 32'(m.we));
          chk("dmem_addr", 32'(dmem_addr), m.addr);
          if (m.we) chk("dmem_wdata", 32'(dmem_wdata), 32'(m.data));
          if (w >= dmem_wait) begin
            dmem_ack = 1'b1;
            if (dmem_we) dmem[dmem_addr] = dmem_wdata;
            else dmem_rdata = dmem[dmem_addr];
            void'(mem_q.pop_front());
            w = 0;
          end else begin
            dmem_ack = 1'b0; w++;
          end
        end
      end else begin
        dmem_ack = stray; w = 0;
      end
    end
  end

  // Retire monitor: cycle 0 is the first FETCH cycle after reset release.
  initial begin
    int unsigned cyc, last;
    ret_t r;
    cyc = 0; last = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0; last = 0;
      end else begin
        if (retire) begin
          if (ret_q.size() == 0) chk("retire_unexpected", 32'(retire), 0);
          else begin
            r = ret_q.pop_front();
            chk("retire_pc", 32'(dbg_pc), r.pc);
            chk("retire_lat", cyc - last, r.lat);
          end
          last = cyc;
        end
        cyc++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic start_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 1024; i++) begin
      imem[i] = enc_o(OP_HALT, 0, 0);
      dmem[i] = '0;
    end
    ret_q.delete();
    mem_q.delete();
  endtask

  task automatic release_reset();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_halt(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    chk({tag, "_halted"}, 32'(halted), 1);
    @(negedge clk);
    chk({tag, "_retq_left"}, ret_q.size(), 0);
    chk({tag, "_memq_left"}, mem_q.size(), 0);
  endtask

  initial begin
    int unsigned bad;

    // Reset mid-fetch with the acknowledge withheld
    imem_hold = 1'b1;
    release_reset();
    repeat (3) @(negedge clk);
    chk("t1_req_waiting", 32'(imem_req), 1);
    chk("t1_addr_waiting", 32'(imem_addr), 0);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("t1_req_in_reset", 32'(imem_req), 0);
    chk("t1_dreq_in_reset", 32'(dmem_req), 0);
    chk("t1_state_in_reset", 32'(dbg_state), 0);
    chk("t1_retire_in_reset", 32'(retire), 0);
    chk("t1_halted_in_reset", 32'(halted), 0);

    // ALU, flags, branches, load/store program
    start_reset();
    imem_hold = 1'b0;
    imem[0]  = enc_i(OP_ADDI, 1, 0, -1);    exp_ret(1, 4);
    imem[1]  = enc_r(OP_ADD, 2, 1, 1);      exp_ret(2, 4);
    imem[2]  = enc_o(OP_BEQ, 0, 5);         exp_ret(3, 3);
    imem[3]  = enc_o(OP_BC, 0, 1);          exp_ret(5, 3);
    imem[5]  = enc_o(OP_ST, 1, 1);          exp_ret(6, 4);  exp_mem(1, 1, 18'h3FFFF);
    imem[6]  = enc_o(OP_ST, 2, 5);          exp_ret(7, 4);  exp_mem(1, 5, 18'h3FFFE);
    imem[7]  = enc_o(OP_LD, 3, 5);          exp_ret(8, 5);  exp_mem(0, 5, '0);
    imem[8]  = enc_o(OP_ST, 3, 6);          exp_ret(9, 4);  exp_mem(1, 6, 18'h3FFFE);
    imem[9]  = enc_r(OP_XOR, 4, 3, 2);      exp_ret(10, 4);
    imem[10] = enc_o(OP_BNE, 0, 20);        exp_ret(11, 3);
    imem[11] = enc_o(OP_BC, 0, 3);          exp_ret(12, 3);
    imem[12] = enc_o(OP_BEQ, 0, 1);         exp_ret(14, 3);
    imem[14] = enc_r(OP_SUB, 5, 0, 1);      exp_ret(15, 4);
    imem[15] = enc_o(OP_ST, 5, 2);          exp_ret(16, 4); exp_mem(1, 2, 18'h00001);
    imem[16] = enc_o(OP_BC, 0, 1);          exp_ret(18, 3);
    imem[18] = enc_i(OP_ANDI, 7, 1, 6'h15); exp_ret(19, 4);
    imem[19] = enc_o(OP_ST, 7, 3);          exp_ret(20, 4); exp_mem(1, 3, 18'h00015);
    imem[20] = enc_r(OP_OR, 8, 7, 2);       exp_ret(21, 4);
    imem[21] = enc_r(OP_AND, 9, 8, 5);      exp_ret(22, 4);
    imem[22] = enc_o(OP_ST, 9, 4);          exp_ret(23, 4); exp_mem(1, 4, 18'h00001);
    imem[23] = enc_o(OP_BC, 0, 2);          exp_ret(24, 3);
    imem[24] = enc_o(OP_NOP, 0, 0);         exp_ret(25, 3);
    imem[25] = enc_r(OP_CMP, 0, 2, 1);      exp_ret(26, 4);
    imem[26] = enc_o(OP_BC, 0, 1);          exp_ret(28, 3);
    imem[28] = enc_r(OP_ADD, 11, 1, 5);     exp_ret(29, 4);
    imem[29] = enc_o(OP_BEQ, 0, 1);         exp_ret(31, 3);
    imem[31] = enc_o(OP_ST, 11, 7);         exp_ret(32, 4); exp_mem(1, 7, 18'h00000);
    imem[32] = enc_i(OP_ADDI, 1, 1, 1);     exp_ret(33, 4);
    imem[33] = enc_o(OP_ST, 1, 8);          exp_ret(34, 4); exp_mem(1, 8, 18'h00000);
    imem[34] = enc_o(OP_HALT, 0, 0);        exp_ret(34, 3);
    release_reset();
    #1;
    chk("t1_req_after_release", 32'(imem_req), 1);
    chk("t1_addr_after_release", 32'(imem_addr), 0);
    wait_halt("prog", 400);

    // Halted core stays quiet and ignores stray acknowledges
    stray = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req || dmem_req || retire || !halted) bad++;
    end
    stray = 1'b0;
    chk("halt_quiet_cycles", bad, 0);
    chk("halt_pc", 32'(dbg_pc), 34);
    chk("halt_state", 32'(dbg_state), 5);

    // Instruction fetch stalls of three cycles, data stalls of two
    start_reset();
    chk("reset_clears_halted", 32'(halted), 0);
    imem_wait = 3;
    dmem_wait = 2;
    imem[0] = enc_i(OP_ADDI, 1, 0, 5);  exp_ret(1, 7);
    imem[1] = enc_o(OP_ST, 1, 9);       exp_ret(2, 9); exp_mem(1, 9, 18'h00005);
    imem[2] = enc_o(OP_HALT, 0, 0);     exp_ret(2, 6);
    release_reset();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!imem_req || imem_addr != '0) bad++;
    end
    chk("stall_req_addr_stable", bad, 0);
    wait_halt("stall", 100);
    imem_wait = 0;
    dmem_wait = 0;

    // PC-relative branch across the top of the address space, taken
    start_reset();
    imem[0]    = enc_o(OP_JMP, 0, 1020);  exp_ret(1021, 3);
    imem[1021] = enc_r(OP_CMP, 0, 1, 1);  exp_ret(1022, 4);
    imem[1022] = enc_o(OP_BEQ, 0, -3);    exp_ret(1020, 3);
    exp_ret(1020, 3);
    release_reset();
    wait_halt("wrap_beq", 100);

    // Same point with BNE falling through, then PC wrapping to 0
    start_reset();
    imem[0]    = enc_o(OP_JMP, 0, 1020);  exp_ret(1021, 3);
    imem[1021] = enc_r(OP_CMP, 0, 1, 1);  exp_ret(1022, 4);
    imem[1022] = enc_o(OP_BNE, 0, -3);    exp_ret(1023, 3);
    imem[1023] = enc_o(OP_BC, 0, -3);     exp_ret(0, 3);
    exp_ret(0, 3);
    release_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_pc == 10'd1021) break;
    end
    chk("wrap_bne_reach", 32'(dbg_pc), 1021);
    imem[0] = enc_o(OP_HALT, 0, 0);
    wait_halt("wrap_bne", 100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
